// File: rtl/uart1_pkg.sv
// Shared constants for the uart1 receiver and transmitter.
// Holds the state encoding, the default bit period and the data width.
package uart1_pkg;

    localparam int CLKS_PER_BIT_DEF = 16;
    localparam int DATA_BITS        = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart1_state_e;

endpackage

// File: rtl/uart1_rx_if.sv
// Serial-in / byte-out signal bundle of the uart1 receiver.
interface uart1_rx_if;
    import uart1_pkg::*;

    logic                 rx1;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport slave  (input rx1, output data_out, data_valid, frame_err, busy);
    modport master (output rx1, input data_out, data_valid, frame_err, busy);

endinterface

// File: rtl/uart1_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector.
module uart1_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_i,
    output logic rx_s_o,
    output logic fall_o
);

    logic meta_q, sync_q, prev_q;

    // Flops reset to the idle-high level so release never fakes a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rx_s_o = sync_q;
    assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/uart1_rx.sv
// 8N1 UART receiver: start-bit check at mid bit, then one sample per bit period.
module uart1_rx
    import uart1_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    uart1_rx_if.slave  bus
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam int             BW       = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s, fall;

    uart1_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .rx_i   (bus.rx1),
        .rx_s_o (rx_s),
        .fall_o (fall)
    );

    uart1_state_e         state_q;
    logic [CW-1:0]        cnt_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fall) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        // A line back high at mid start bit was only a glitch.
                        state_q <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (cnt_q == CNT_FULL) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A break only reports once; resume after the line idles.
                    if (rx_s) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart1_rx.sv
// Directed and randomized frames against a byte-level model of the receiver.
module tb_uart1_rx;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart1_rx_if u_if ();

    uart1_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Observed pulses, recorded away from the clock edge.
    logic [7:0] got_q[$];
    int         n_ferr   = 0;
    int         n_both   = 0;
    int         n_double = 0;
    logic       prev_v   = 1'b0;
    logic       prev_f   = 1'b0;

    always @(negedge clk) begin
        if (u_if.data_valid) got_q.push_back(u_if.data_out);
        if (u_if.frame_err) n_ferr++;
        if (u_if.data_valid && u_if.frame_err) n_both++;
        if ((u_if.data_valid && prev_v) || (u_if.frame_err && prev_f)) n_double++;
        prev_v = u_if.data_valid;
        prev_f = u_if.frame_err;
    end

    // Reference model: a good stop bit delivers the byte, a bad one only flags.
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;
    int         exp_ferr = 0;

    function automatic void model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            exp_q.push_back(b);
            exp_data = b;
        end else begin
            exp_ferr++;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            u_if.rx1 = bits[i];
            cyc(CPB);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_nvalid"}, got_q.size(), exp_q.size());
        check({tag, "_nferr"}, n_ferr, exp_ferr);
        check({tag, "_data"}, u_if.data_out, exp_data);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (u_if.busy !== 1'b0 && n < budget) begin
            cyc(1);
            n++;
        end
        check({tag, "_idle"}, u_if.busy, 1'b0);
    endtask

    initial begin
        int n;
        logic [7:0] b;
        logic       s;

        u_if.rx1 = 1'b1;
        cyc(5);
        check("rst_data", u_if.data_out, 8'h00);
        check("rst_valid", u_if.data_valid, 1'b0);
        check("rst_ferr", u_if.frame_err, 1'b0);
        check("rst_busy", u_if.busy, 1'b0);
        rst = 1'b1;
        cyc(5);

        send_frame(8'h5B, 1'b1);
        model_frame(8'h5B, 1'b1);
        cyc(4);
        check_model("f5b");
        check("f5b_busy", u_if.busy, 1'b0);

        // Short low pulse is rejected at the mid-start check.
        u_if.rx1 = 1'b0;
        cyc(4);
        check("glitch_busy_hi", u_if.busy, 1'b1);
        u_if.rx1 = 1'b1;
        n = 0;
        while (u_if.busy !== 1'b0 && n < 20) begin
            cyc(1);
            n++;
        end
        check("glitch_fast", (n < 10), 1'b1);
        cyc(4);
        check_model("glitch");

        send_frame(8'hA5, 1'b0);
        model_frame(8'hA5, 1'b0);
        cyc(2 * CPB);
        check("a5_waithigh", u_if.busy, 1'b1);
        check_model("a5");
        u_if.rx1 = 1'b1;
        wait_idle("a5", 10);

        cyc(CPB);
        send_frame(8'h00, 1'b1);
        model_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        model_frame(8'hFF, 1'b1);
        cyc(4);
        check_model("b2b");

        // Reset in the middle of data bit 4 of 0x3C.
        u_if.rx1 = 1'b0;
        cyc(CPB);
        b = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            u_if.rx1 = b[i];
            cyc(CPB);
        end
        u_if.rx1 = b[4];
        cyc(CPB / 2);
        check("mid_busy", u_if.busy, 1'b1);
        rst = 1'b0;
        #1;
        exp_data = 8'h00;
        check("mrst_data", u_if.data_out, 8'h00);
        check("mrst_valid", u_if.data_valid, 1'b0);
        check("mrst_ferr", u_if.frame_err, 1'b0);
        check("mrst_busy", u_if.busy, 1'b0);
        u_if.rx1 = 1'b1;
        cyc(3);
        rst = 1'b1;
        cyc(5);
        send_frame(8'h81, 1'b1);
        model_frame(8'h81, 1'b1);
        cyc(4);
        check_model("f81");

        // Break: line low for 20 bit times gives one error only.
        u_if.rx1 = 1'b0;
        cyc(20 * CPB);
        exp_ferr++;
        check("brk_busy", u_if.busy, 1'b1);
        check_model("brk");
        u_if.rx1 = 1'b1;
        wait_idle("brk", 10);
        cyc(CPB);

        for (int k = 0; k < 24; k++) begin
            b = 8'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send_frame(b, s);
            model_frame(b, s);
            u_if.rx1 = 1'b1;
            check("rnd_cnt", got_q.size() + n_ferr, exp_q.size() + exp_ferr);
            cyc(s ? $urandom_range(0, 20) : CPB);
        end
        cyc(2 * CPB);
        check_model("rnd");
        check("never_both", n_both, 0);
        check("single_pulse", n_double, 0);
        check("end_busy", u_if.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
